// File: rtl/axi_pkg.sv
// Shared AXI4-Lite response codes and decoder
// state encoding.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [3:0] {
    IDLE,
    AW_FWD,
    W_ACC,
    W_FWD,
    B_WAIT,
    B_RET,
    AR_FWD,
    R_WAIT,
    R_RET
  } dec_state_e;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/axi_addr_decode.sv
// Maps an address onto a slave index and a
// hit flag for the window starting at BASE_ADDR.
module axi_addr_decode #(
  parameter int ADDR_W = 32,
  parameter int NUM_SLAVES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int REGION_BITS = 16,
  parameter int SEL_W = 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel,
  output logic              hit
);

  logic [ADDR_W-1:0] idx;

  assign idx = (addr - BASE_ADDR) >> REGION_BITS;
  assign sel = idx[SEL_W-1:0];
  assign hit = (addr >= BASE_ADDR)
            && (idx < ADDR_W'(NUM_SLAVES));

endmodule

// File: rtl/axi_slave_decoder.sv
// Single-outstanding AXI4-Lite 1:N decoder with
// DECERR termination of unmapped accesses.
module axi_slave_decoder #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int REGION_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_awvalid,
  output logic                         m_awready,
  input  logic [ADDR_W-1:0]            m_awaddr,
  input  logic                         m_wvalid,
  output logic                         m_wready,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_bvalid,
  input  logic                         m_bready,
  output logic [1:0]                   m_bresp,
  input  logic                         m_arvalid,
  output logic                         m_arready,
  input  logic [ADDR_W-1:0]            m_araddr,
  output logic                         m_rvalid,
  input  logic                         m_rready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [1:0]                   m_rresp,
  output logic [ADDR_W-1:0]            s_awaddr,
  output logic [ADDR_W-1:0]            s_araddr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic [NUM_SLAVES-1:0]        s_awvalid,
  output logic [NUM_SLAVES-1:0]        s_wvalid,
  output logic [NUM_SLAVES-1:0]        s_bready,
  output logic [NUM_SLAVES-1:0]        s_arvalid,
  output logic [NUM_SLAVES-1:0]        s_rready,
  input  logic [NUM_SLAVES-1:0]        s_awready,
  input  logic [NUM_SLAVES-1:0]        s_wready,
  input  logic [NUM_SLAVES-1:0]        s_bvalid,
  input  logic [NUM_SLAVES-1:0]        s_arready,
  input  logic [NUM_SLAVES-1:0]        s_rvalid,
  input  logic [2*NUM_SLAVES-1:0]      s_bresp,
  input  logic [2*NUM_SLAVES-1:0]      s_rresp,
  input  logic [DATA_W*NUM_SLAVES-1:0] s_rdata,
  output logic [7:0]                   decerr_cnt
);
  import axi_pkg::*;

  localparam int SEL_W =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  dec_state_e state, state_nx;

  logic [ADDR_W-1:0]     addr_q;
  logic [SEL_W-1:0]      sel_q;
  logic                  hit_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            bresp_q;
  logic [1:0]            rresp_q;

  logic [SEL_W-1:0]      aw_sel, ar_sel;
  logic                  aw_hit, ar_hit;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic                  aw_hs, ar_hs;
  logic                  b_hs, r_hs, dec_hs;
  logic                  awr_sel, wr_sel, arr_sel;
  logic                  bv_sel, rv_sel;
  logic [1:0]            bresp_sel, rresp_sel;
  logic [DATA_W-1:0]     rdata_sel;

  axi_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS),
    .SEL_W       (SEL_W)
  ) u_aw_dec (
    .addr (m_awaddr),
    .sel  (aw_sel),
    .hit  (aw_hit)
  );

  axi_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS),
    .SEL_W       (SEL_W)
  ) u_ar_dec (
    .addr (m_araddr),
    .sel  (ar_sel),
    .hit  (ar_hit)
  );

  assign sel_oh    = NUM_SLAVES'(1) << sel_q;
  assign awr_sel   = s_awready[sel_q];
  assign wr_sel    = s_wready[sel_q];
  assign arr_sel   = s_arready[sel_q];
  assign bv_sel    = s_bvalid[sel_q];
  assign rv_sel    = s_rvalid[sel_q];
  assign bresp_sel = s_bresp[2*sel_q +: 2];
  assign rresp_sel = s_rresp[2*sel_q +: 2];
  assign rdata_sel = s_rdata[DATA_W*sel_q +: DATA_W];

  // Write wins a same-cycle AW/AR collision.
  assign aw_hs = (state == IDLE) && m_awvalid;
  assign ar_hs = (state == IDLE) && m_arvalid
              && !m_awvalid;
  assign b_hs  = m_bvalid && m_bready;
  assign r_hs  = m_rvalid && m_rready;
  assign dec_hs =
    (b_hs && (bresp_q == DECERR))
    || (r_hs && (rresp_q == DECERR));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (aw_hs)
          state_nx = aw_hit ? AW_FWD : W_ACC;
        else if (ar_hs)
          state_nx = ar_hit ? AR_FWD : R_RET;
      end
      AW_FWD: if (awr_sel) state_nx = W_ACC;
      W_ACC: begin
        if (m_wvalid)
          state_nx = hit_q ? W_FWD : B_RET;
      end
      W_FWD:  if (wr_sel)   state_nx = B_WAIT;
      B_WAIT: if (bv_sel)   state_nx = B_RET;
      B_RET:  if (m_bready) state_nx = IDLE;
      AR_FWD: if (arr_sel)  state_nx = R_WAIT;
      R_WAIT: if (rv_sel)   state_nx = R_RET;
      R_RET:  if (m_rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_awready = 1'b0;
    m_arready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_rvalid  = 1'b0;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    s_arvalid = '0;
    s_rready  = '0;
    unique case (state)
      IDLE: begin
        m_awready = 1'b1;
        m_arready = !m_awvalid;
      end
      AW_FWD: s_awvalid = sel_oh;
      W_ACC:  m_wready  = 1'b1;
      W_FWD:  s_wvalid  = sel_oh;
      B_WAIT: s_bready  = sel_oh;
      B_RET:  m_bvalid  = 1'b1;
      AR_FWD: s_arvalid = sel_oh;
      R_WAIT: s_rready  = sel_oh;
      R_RET:  m_rvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      sel_q      <= '0;
      hit_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      decerr_cnt <= '0;
    end else begin
      if (aw_hs) begin
        addr_q <= m_awaddr;
        sel_q  <= aw_sel;
        hit_q  <= aw_hit;
      end else if (ar_hs) begin
        addr_q <= m_araddr;
        sel_q  <= ar_sel;
        hit_q  <= ar_hit;
        if (!ar_hit) begin
          rdata_q <= '0;
          rresp_q <= DECERR;
        end
      end
      if ((state == W_ACC) && m_wvalid) begin
        wdata_q <= m_wdata;
        wstrb_q <= m_wstrb;
        if (!hit_q) bresp_q <= DECERR;
      end
      if ((state == B_WAIT) && bv_sel)
        bresp_q <= bresp_sel;
      if ((state == R_WAIT) && rv_sel) begin
        rdata_q <= rdata_sel;
        rresp_q <= rresp_sel;
      end
      if (dec_hs && (decerr_cnt != CNT_MAX))
        decerr_cnt <= decerr_cnt + 8'd1;
    end
  end

  assign m_bresp  = bresp_q;
  assign m_rresp  = rresp_q;
  assign m_rdata  = rdata_q;
  assign s_awaddr = addr_q;
  assign s_araddr = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;

endmodule

// File: tb/tb_axi_slave_decoder.sv
// Directed bench for axi_slave_decoder: scoreboard
// of master responses plus slave-side monitors.
module tb_axi_slave_decoder;
  import axi_pkg::*;

  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit            rd;
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          m_awvalid, m_awready;
  logic [AW-1:0] m_awaddr;
  logic          m_wvalid, m_wready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_bvalid, m_bready;
  logic [1:0]    m_bresp;
  logic          m_arvalid, m_arready;
  logic [AW-1:0] m_araddr;
  logic          m_rvalid, m_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;
  logic [3:0]    s_wstrb;
  logic [NS-1:0] s_awvalid, s_wvalid, s_bready;
  logic [NS-1:0] s_arvalid, s_rready;
  logic [NS-1:0] s_awready, s_wready, s_bvalid;
  logic [NS-1:0] s_arready, s_rvalid;
  logic [2*NS-1:0] s_bresp, s_rresp;
  logic [DW*NS-1:0] s_rdata;
  logic [7:0]    decerr_cnt;

  axi_slave_decoder #(
    .NUM_SLAVES  (NS),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BASE_ADDR   (32'h0000_0000),
    .REGION_BITS (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_awaddr   (m_awaddr),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .m_bresp    (m_bresp),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_araddr   (m_araddr),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .s_awaddr   (s_awaddr),
    .s_araddr   (s_araddr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_awvalid  (s_awvalid),
    .s_wvalid   (s_wvalid),
    .s_bready   (s_bready),
    .s_arvalid  (s_arvalid),
    .s_rready   (s_rready),
    .s_awready  (s_awready),
    .s_wready   (s_wready),
    .s_bvalid   (s_bvalid),
    .s_arready  (s_arready),
    .s_rvalid   (s_rvalid),
    .s_bresp    (s_bresp),
    .s_rresp    (s_rresp),
    .s_rdata    (s_rdata),
    .decerr_cnt (decerr_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];

  function automatic void chk(string nm,
      logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endfunction

  // Slave models: ready/response after a
  // programmable number of valid cycles.
  int aw_dly[NS], w_dly[NS], ar_dly[NS];
  int b_dly[NS], r_dly[NS];
  int aw_c[NS], w_c[NS], ar_c[NS];
  int b_c[NS], r_c[NS];
  logic [1:0]    bresp_cfg[NS], rresp_cfg[NS];
  logic [DW-1:0] rdata_cfg[NS];

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      aw_c[i] <= s_awvalid[i] ? aw_c[i] + 1 : 0;
      w_c[i]  <= s_wvalid[i]  ? w_c[i] + 1  : 0;
      ar_c[i] <= s_arvalid[i] ? ar_c[i] + 1 : 0;
      b_c[i]  <= s_bready[i]  ? b_c[i] + 1  : 0;
      r_c[i]  <= s_rready[i]  ? r_c[i] + 1  : 0;
    end
  end

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_arready = '0;
    s_bvalid  = '0;
    s_rvalid  = '0;
    s_bresp   = '0;
    s_rresp   = '0;
    s_rdata   = '0;
    for (int i = 0; i < NS; i++) begin
      s_awready[i] = s_awvalid[i] && aw_c[i] >= aw_dly[i];
      s_wready[i]  = s_wvalid[i]  && w_c[i] >= w_dly[i];
      s_arready[i] = s_arvalid[i] && ar_c[i] >= ar_dly[i];
      s_bvalid[i]  = s_bready[i]  && b_c[i] >= b_dly[i];
      s_rvalid[i]  = s_rready[i]  && r_c[i] >= r_dly[i];
      s_bresp[2*i +: 2]  = bresp_cfg[i];
      s_rresp[2*i +: 2]  = rresp_cfg[i];
      s_rdata[DW*i +: DW] = rdata_cfg[i];
    end
  end

  // Slave-side monitor and response scoreboard.
  int awv_c[NS], arv_c[NS];
  int wv_c, bad_oh;
  logic [AW-1:0] seen_awaddr, seen_araddr;
  logic [DW-1:0] seen_wdata;
  logic [3:0]    seen_wstrb;
  exp_t e;

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_awvalid[i]) awv_c[i]++;
      if (s_arvalid[i]) arv_c[i]++;
    end
    if (s_wvalid != '0) begin
      wv_c++;
      seen_wdata = s_wdata;
      seen_wstrb = s_wstrb;
    end
    if (s_awvalid != '0) seen_awaddr = s_awaddr;
    if (s_arvalid != '0) seen_araddr = s_araddr;
    if (!$onehot0(s_awvalid) || !$onehot0(s_wvalid)
        || !$onehot0(s_bready)
        || !$onehot0(s_arvalid)
        || !$onehot0(s_rready))
      bad_oh++;
    if (rst && m_bvalid && m_bready) begin
      chk("b_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("b_order", e.rd, 0);
        chk("m_bresp", m_bresp, e.resp);
      end
    end
    if (rst && m_rvalid && m_rready) begin
      chk("r_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("r_order", e.rd, 1);
        chk("m_rresp", m_rresp, e.resp);
        chk("m_rdata", m_rdata, e.data);
      end
    end
  end

  task automatic clr_mon();
    for (int i = 0; i < NS; i++) begin
      awv_c[i] = 0;
      arv_c[i] = 0;
    end
    wv_c = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] a,
      input logic [DW-1:0] d, input logic [3:0] st,
      input logic [1:0] er, input int bwait,
      output int lat);
    bit aw_done, done, aw_f, w_f;
    int held, since;
    logic [1:0] r0;
    sb.push_back('{rd: 1'b0, resp: er, data: '0});
    aw_done = 0; done = 0; held = 0; since = 0;
    lat = -1; r0 = '0;
    @(posedge clk); #1;
    m_awvalid = 1; m_awaddr = a;
    m_wvalid = 1; m_wdata = d; m_wstrb = st;
    m_bready = (bwait == 0);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      aw_f = m_awvalid && m_awready;
      w_f  = m_wvalid && m_wready;
      if (aw_done) since++;
      if (m_bvalid) begin
        if (lat < 0) lat = since;
        if (m_bready) done = 1;
        else begin
          if (held == 0) r0 = m_bresp;
          else chk("bresp_stable", m_bresp, r0);
          held++;
        end
      end
      @(posedge clk); #1;
      if (aw_f) begin m_awvalid = 0; aw_done = 1; end
      if (w_f) m_wvalid = 0;
      if (done) m_bready = 0;
      else if (m_bvalid && held >= bwait) m_bready = 1;
    end
    chk("write_done", done, 1);
    m_awvalid = 0; m_wvalid = 0; m_bready = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a,
      input logic [DW-1:0] ed, input logic [1:0] er,
      output int lat);
    bit ar_done, done, ar_f;
    int since;
    sb.push_back('{rd: 1'b1, resp: er, data: ed});
    ar_done = 0; done = 0; since = 0; lat = -1;
    @(posedge clk); #1;
    m_arvalid = 1; m_araddr = a; m_rready = 1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      ar_f = m_arvalid && m_arready;
      if (ar_done) since++;
      if (m_rvalid) begin
        lat = since;
        done = 1;
      end
      @(posedge clk); #1;
      if (ar_f) begin m_arvalid = 0; ar_done = 1; end
      if (done) m_rready = 0;
    end
    chk("read_done", done, 1);
    m_arvalid = 0; m_rready = 0;
  endtask

  int lat;
  bit wdone, rdone, hit_bw, aw_f, w_f, ar_f, b_f, r_f;

  initial begin
    m_awvalid = 0; m_awaddr = '0;
    m_wvalid = 0; m_wdata = '0; m_wstrb = '0;
    m_bready = 0; m_arvalid = 0; m_araddr = '0;
    m_rready = 0;
    for (int i = 0; i < NS; i++) begin
      aw_dly[i] = 0; w_dly[i] = 0; ar_dly[i] = 0;
      b_dly[i] = 0; r_dly[i] = 0;
      bresp_cfg[i] = OKAY; rresp_cfg[i] = OKAY;
      rdata_cfg[i] = '0;
    end
    bad_oh = 0;
    clr_mon();
    repeat (3) @(negedge clk);
    chk("rst_bvalid", m_bvalid, 0);
    chk("rst_rvalid", m_rvalid, 0);
    chk("rst_s_ctl", {s_awvalid, s_wvalid, s_bready,
                      s_arvalid, s_rready}, 0);
    chk("rst_decerr", decerr_cnt, 0);
    chk("rst_awready", m_awready, 1);
    chk("rst_arready", m_arready, 1);
    @(posedge clk); #1 rst = 1;

    // Mapped write to slave 1.
    clr_mon();
    do_write(32'h0001_0004, 32'h1234_5678, 4'hA,
             OKAY, 0, lat);
    chk("w1_bvalid_lat", lat, 5);
    chk("w1_awv_s1", awv_c[1], 1);
    chk("w1_awv_s0", awv_c[0], 0);
    chk("w1_awaddr", seen_awaddr, 32'h0001_0004);
    chk("w1_wdata", seen_wdata, 32'h1234_5678);
    chk("w1_wstrb", seen_wstrb, 4'hA);

    // Slave 0 read with delayed arready.
    clr_mon();
    ar_dly[0] = 3;
    rdata_cfg[0] = 32'hDEAD_BEEF;
    do_read(32'h0000_0010, 32'hDEAD_BEEF, OKAY, lat);
    ar_dly[0] = 0;
    chk("r0_arv_s0", arv_c[0], 4);
    chk("r0_arv_s1", arv_c[1], 0);
    chk("r0_lat", lat, 6);
    chk("r0_araddr", seen_araddr, 32'h0000_0010);

    // Unmapped read.
    clr_mon();
    do_read(32'h0005_0000, 32'h0, DECERR, lat);
    chk("ur_no_arv", arv_c[0] + arv_c[1], 0);
    chk("ur_lat", lat, 1);
    chk("ur_decerr", decerr_cnt, 1);

    // Last word of slave 1; SLVERR and EXOKAY pass.
    clr_mon();
    rresp_cfg[1] = SLVERR;
    rdata_cfg[1] = 32'hCAFE_0001;
    do_read(32'h0001_FFFC, 32'hCAFE_0001, SLVERR, lat);
    chk("edge_arv_s1", arv_c[1], 1);
    bresp_cfg[0] = EXOKAY;
    do_write(32'h0000_0000, 32'h5, 4'hF,
             EXOKAY, 0, lat);
    bresp_cfg[0] = OKAY;
    chk("pass_decerr", decerr_cnt, 1);

    // Simultaneous AW and AR: write first.
    rdata_cfg[1] = 32'h0BAD_F00D;
    rresp_cfg[1] = OKAY;
    sb.push_back('{rd: 1'b0, resp: OKAY, data: '0});
    sb.push_back('{rd: 1'b1, resp: OKAY,
                   data: 32'h0BAD_F00D});
    wdone = 0; rdone = 0;
    @(posedge clk); #1;
    m_awvalid = 1; m_awaddr = 32'h0000_0008;
    m_wvalid = 1; m_wdata = 32'h77; m_wstrb = 4'hF;
    m_arvalid = 1; m_araddr = 32'h0001_0020;
    m_bready = 1; m_rready = 1;
    for (int c = 0; c < 100 && !rdone; c++) begin
      @(negedge clk);
      if (c == 0) chk("col_awready", m_awready, 1);
      if (!wdone) chk("col_ar_blocked", m_arready, 0);
      aw_f = m_awvalid && m_awready;
      w_f  = m_wvalid && m_wready;
      ar_f = m_arvalid && m_arready;
      b_f  = m_bvalid && m_bready;
      r_f  = m_rvalid && m_rready;
      if (ar_f) chk("col_rd_after_wr", wdone, 1);
      @(posedge clk); #1;
      if (aw_f) m_awvalid = 0;
      if (w_f) m_wvalid = 0;
      if (ar_f) m_arvalid = 0;
      if (b_f) begin wdone = 1; m_bready = 0; end
      if (r_f) begin rdone = 1; m_rready = 0; end
    end
    chk("col_done", rdone, 1);
    m_arvalid = 0; m_rready = 0;

    // Reset while the slave holds off BVALID.
    chk("pre_rst_decerr", decerr_cnt, 1);
    b_dly[1] = 50;
    hit_bw = 0;
    @(posedge clk); #1;
    m_awvalid = 1; m_awaddr = 32'h0001_0000;
    m_wvalid = 1; m_wdata = 32'h99; m_wstrb = 4'hF;
    m_bready = 1;
    for (int c = 0; c < 50 && !hit_bw; c++) begin
      @(negedge clk);
      aw_f = m_awvalid && m_awready;
      w_f  = m_wvalid && m_wready;
      hit_bw = s_bready[1];
      if (!hit_bw) begin
        @(posedge clk); #1;
        if (aw_f) m_awvalid = 0;
        if (w_f) m_wvalid = 0;
      end
    end
    chk("reach_b_wait", hit_bw, 1);
    m_awvalid = 0; m_wvalid = 0; m_bready = 0;
    #2 rst = 0;
    @(negedge clk);
    chk("mid_rst_bvalid", m_bvalid, 0);
    chk("mid_rst_rvalid", m_rvalid, 0);
    chk("mid_rst_s_ctl", {s_awvalid, s_wvalid,
        s_bready, s_arvalid, s_rready}, 0);
    chk("mid_rst_decerr", decerr_cnt, 0);
    chk("mid_rst_idle", m_awready, 1);
    sb.delete();
    @(posedge clk); #1 rst = 1;
    b_dly[1] = 0;
    do_write(32'h0001_0040, 32'hABCD, 4'h3,
             OKAY, 0, lat);
    chk("post_rst_lat", lat, 5);

    // Saturation over 256 unmapped writes.
    clr_mon();
    for (int k = 1; k <= 256; k++) begin
      do_write(32'h0002_0000 + 32'(k * 4), 32'(k),
               4'hF, DECERR, 2, lat);
      if (k == 1) chk("uw_lat", lat, 2);
      chk("decerr_sat", decerr_cnt,
          (k > 255) ? 255 : k);
    end
    chk("uw_no_awv", awv_c[0] + awv_c[1], 0);
    chk("uw_no_wv", wv_c, 0);
    chk("onehot", bad_oh, 0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
